// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, source index constants and a select
// legality helper for the divided-clock selector family.
package div_pkg;

  // Selector control states.
  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    DRAIN  = 2'd1,
    PARK   = 2'd2
  } div_state_e;

  // Positions of the even-ratio divider outputs in the source vector.
  localparam int SRC_DIV2 = 0;
  localparam int SRC_DIV4 = 1;
  localparam int SRC_DIV6 = 2;

  localparam int N_SRC_DEFAULT = 3;

  // A select index is usable only if it addresses an existing source.
  function automatic logic sel_is_legal(input int sel, input int n_src);
    return (sel >= 0) && (sel < n_src);
  endfunction

endpackage

// File: rtl/div_clk_select_if.sv
// div_clk_select_if: valid/ready request channel carrying a source index
// to the divided-clock selector.
interface div_clk_select_if #(
  parameter int SEL_W = 2
);
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;

  // Requester side drives the index and valid, sees ready.
  modport master (
    output req_valid,
    output req_sel,
    input  req_ready
  );

  // Selector side consumes the index and valid, drives ready.
  modport slave (
    input  req_valid,
    input  req_sel,
    output req_ready
  );
endinterface

// File: rtl/rise_detect.sv
// rise_detect: registers each input bit once per cycle and flags bits that
// are high now but were low on the previous cycle.
module rise_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] d_q;

  // One cycle of history per bit; cleared by reset so a level-high input
  // right after reset reads as a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= '0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/div_clk_select.sv
// div_clk_select: glitch-free selector between divided waveforms that are
// all sampled in the clk domain. A switch lets the old source finish its
// high phase (DRAIN), holds the output low (PARK) and only hands over on a
// fresh rise of the new source, so no output phase is ever truncated.
//
// Optional build macro DIV_CLK_SELECT_STATS_EN adds switch_cnt/err_cnt.
//
// state  | meaning
// FOLLOW | div_out tracks src[cur_sel]; requests accepted
// DRAIN  | waiting for the old source's high phase to end
// PARK   | output held low, waiting for a rise on the target
module div_clk_select
  import div_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEFAULT,
  parameter int SEL_W       = $clog2(N_SRC),
  parameter int DEFAULT_SEL = SRC_DIV2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  div_clk_select_if.slave  req,
  output logic             div_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             switch_done,
`ifdef DIV_CLK_SELECT_STATS_EN
  output logic             switch_err,
  output logic [15:0]      switch_cnt,
  output logic [7:0]       err_cnt
`else
  output logic             switch_err
`endif
);

  // Timer has one spare bit above the terminal count so it can saturate.
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]    TIMER_MAX  = {TW{1'b1}};
  localparam logic [SEL_W-1:0] SEL_RESET  = SEL_W'(DEFAULT_SEL);

  div_state_e       state_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic [SEL_W-1:0] tgt_q;
  logic [TW-1:0]    timer_q;
  logic             div_out_q;
  logic             done_q;
  logic             err_q;

  logic [N_SRC-1:0] src_rise;
  logic             cur_bit;
  logic             tgt_rise;
  logic             accept;
  logic             sel_legal;
  logic             sel_same;
  logic             timer_last;
  logic [TW-1:0]    timer_inc;

  rise_detect #(
    .W (N_SRC)
  ) u_rise (
    .clk    (clk),
    .reset  (reset),
    .d_i    (src),
    .rise_o (src_rise)
  );

  assign cur_bit     = src[cur_sel_q];
  assign tgt_rise    = src_rise[tgt_q];
  assign req.req_ready = (state_q == FOLLOW);
  assign accept      = req.req_valid && req.req_ready;
  assign sel_legal   = sel_is_legal(int'(req.req_sel), N_SRC);
  assign sel_same    = (req.req_sel == cur_sel_q);
  assign timer_last  = (timer_q == TIMER_LAST);
  assign timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

  // Selector FSM with registered output, index and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FOLLOW;
      cur_sel_q <= SEL_RESET;
      tgt_q     <= SEL_RESET;
      timer_q   <= '0;
      div_out_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        FOLLOW: begin
          div_out_q <= cur_bit;
          if (accept) begin
            if (!sel_legal) begin
              err_q <= 1'b1;
            end else if (sel_same) begin
              done_q <= 1'b1;
            end else begin
              tgt_q   <= req.req_sel;
              timer_q <= '0;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          timer_q <= timer_inc;
          if (timer_last) begin
            // Give up; keep following the old source without a gap.
            err_q     <= 1'b1;
            div_out_q <= cur_bit;
            state_q   <= FOLLOW;
          end else if (!cur_bit) begin
            div_out_q <= 1'b0;
            state_q   <= PARK;
          end else begin
            div_out_q <= cur_bit;
          end
        end
        PARK: begin
          timer_q <= timer_inc;
          // A fresh rise beats a coincident timeout.
          if (tgt_rise) begin
            div_out_q <= 1'b1;
            cur_sel_q <= tgt_q;
            done_q    <= 1'b1;
            state_q   <= FOLLOW;
          end else if (timer_last) begin
            err_q     <= 1'b1;
            div_out_q <= cur_bit;
            state_q   <= FOLLOW;
          end else begin
            div_out_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= FOLLOW;
          div_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_out     = div_out_q;
  assign cur_sel     = cur_sel_q;
  assign switch_done = done_q;
  assign switch_err  = err_q;

`ifdef DIV_CLK_SELECT_STATS_EN
  logic [15:0] switch_cnt_q;
  logic [7:0]  err_cnt_q;

  // Completed switches wrap; errors saturate so a burst stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      switch_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (done_q) begin
        switch_cnt_q <= switch_cnt_q + 16'd1;
      end
      if (err_q && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign switch_cnt = switch_cnt_q;
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: doc/div_clk_select.md
Name: div_clk_select

Overview:
- Sits directly downstream of the even-ratio divider.
- Takes its divided waveforms (div2, div4, div6, …) as a source vector, all sampled in the clk domain.
- Outputs one selected divided waveform, div_out; the selection changes at run time via a valid/ready request.
- Switches glitch-free: no high or low phase on div_out is ever shorter than the narrower phase of the old or new source.

Parameters:
- N_SRC, 3: number of divided source inputs; index 0=div2, 1=div4, 2=div6.
- SEL_W, $clog2(N_SRC): width of the select index.
- DEFAULT_SEL, 0: source followed out of reset.
- TIMEOUT_CYC, 64: max cycles spent in DRAIN+PARK before the switch is abandoned.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous reset, active-high.
- src, input, N_SRC: divided waveforms; bit i = source i.
- req_valid, input, 1: switch request valid.
- req_sel, input, SEL_W: requested source index.
- req_ready, output, 1: high only in FOLLOW; a request is accepted when req_valid && req_ready.
- div_out, output, 1: selected waveform, registered.
- cur_sel, output, SEL_W: index currently followed.
- switch_done, output, 1: 1-cycle pulse when a switch completes, including a same-source request.
- switch_err, output, 1: 1-cycle pulse on an illegal req_sel or a timeout.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=FOLLOW, cur_sel=DEFAULT_SEL, div_out=0, src_q=0, timeout counter=0, switch_done=0, switch_err=0.
- src_q: register of src, updated every cycle.
- Rise of source i: src[i] && !src_q[i].
- Reset asserted mid-switch: returns to the reset state on the next edge. Any pending target is discarded. No done or err pulse.
- FOLLOW:
  - div_out <= src[cur_sel], i.e. one cycle latency from src.
  - On accept with req_sel >= N_SRC: switch_err pulses, state is unchanged, the request is consumed.
  - On accept with req_sel == cur_sel: switch_done pulses next cycle, no state change.
  - On accept otherwise: tgt <= req_sel, timer <= 0, go to DRAIN.
- DRAIN:
  - div_out <= src[cur_sel].
  - When src[cur_sel]==0: div_out <= 0, go to PARK.
  - If src[cur_sel] is already 0 on the entry cycle, PARK is entered on the next edge.
- PARK:
  - div_out <= 0.
  - On rise of src[tgt]: div_out <= 1, cur_sel <= tgt, switch_done pulse, go to FOLLOW.
  - A level-high src[tgt] on entry does NOT count; wait for a fresh rise so a full high phase is produced.
- Timeout:
  - The timer counts every cycle in DRAIN or PARK.
  - When the timer reaches TIMEOUT_CYC-1: go to FOLLOW, cur_sel unchanged, switch_err pulse, div_out <= src[cur_sel].
  - Timer width is $clog2(TIMEOUT_CYC)+1; it saturates and never wraps.
- Back-pressure: req_ready=0 in DRAIN and PARK. A request held during that time is accepted in the first FOLLOW cycle.
- Simultaneous events: a rise of the target and a timeout on the same cycle → the rise wins (switch completes, no err).
- switch_done and switch_err are never high in the same cycle.

Optional Feature:
- Macro: DIV_CLK_SELECT_STATS_EN.
- Defined:
  - Adds output switch_cnt[15:0], reset 0, incremented on each switch_done pulse, wraps 0xFFFF→0.
  - Adds output err_cnt[7:0], saturating at 0xFF.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package div_pkg holds:
  - state enum {FOLLOW, DRAIN, PARK};
  - source index constants SRC_DIV2=0, SRC_DIV4=1, SRC_DIV6=2;
  - N_SRC_DEFAULT=3.
- One natural sub-module, rise_detect: per-bit src_q register plus rise vector, reused by later stages.
- Everything else stays in one file.

Test Plan:
- Test stimulus: a bench divider drives src from counters with the following patterns after reset.
  - div2: high on odd cycles.
  - div4: high when cnt4 is 1 or 2.
  - div6: high when cnt6 is 1, 2 or 3.
- Reset, no requests → div_out tracks div2 delayed 1 cycle; cur_sel=0, req_ready=1, no pulses.
- Request sel=2 while div2 high:
  - DRAIN 1 cycle, then PARK.
  - div_out stays low until the first fresh rise of div6, then is high 3 cycles / low 3 cycles.
  - switch_done pulses once; cur_sel=2; no low phase shorter than 1 cycle and no high phase shorter than 1 cycle.
- Request sel=1 while cur_sel=1 → switch_done pulse the next cycle, state stays FOLLOW, div_out uninterrupted.
- Request sel=3 → switch_err pulse, cur_sel unchanged, req_ready stays 1.
- TIMEOUT_CYC=8, target source tied low → switch_err after 8 cycles in DRAIN+PARK; returns to FOLLOW on the old source.
- Reset asserted in PARK → next cycle state=FOLLOW, cur_sel=0, div_out=0, no done or err; with the macro defined, switch_cnt=0.
